// File: rtl/ifetch_ctrl_if.sv
// Bus bundle for ifetch_ctrl: redirect request, instruction-memory port and decode handshake.
// master = fetch controller side, slave = environment (EX/imem/decode) side.
interface ifetch_ctrl_if #(parameter int ADDR_W = 32);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;
    logic              if_ready;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: issues imem reads, queues in-order returns, hands them to decode, applies redirects.
// Defining IFETCH_PERF_CNT_EN adds the perf_fetch_cnt/perf_flush_cnt counters.
module ifetch_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    ifetch_ctrl_if.master bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_flush_cnt
`endif
);

    localparam int                CNT_W      = $clog2(DEPTH + 1);
    localparam int                PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] fetch_pc, deliver_pc, target_pc;
    logic [CNT_W-1:0]  inflight, inflight_next;
    logic [CNT_W-1:0]  count, count_next;
    logic [CNT_W-1:0]  discard, discard_next;
    logic [CNT_W:0]    occupancy;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [31:0]       queue [DEPTH];
    logic [31:0]       last_instr;
    logic              redirect, issue, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign redirect  = bus.redirect_valid;
    assign target_pc = bus.redirect_pc & ALIGN_MASK;

    // Reads in flight already own a queue slot, so a returning word always finds room.
    assign occupancy    = {1'b0, inflight} + {1'b0, count};
    assign bus.imem_req = (state != BOOT) && !redirect && (occupancy < (CNT_W + 1)'(DEPTH));
    assign bus.imem_addr = fetch_pc;

    assign bus.if_valid = (count != '0) && !redirect;
    assign bus.if_instr = (count != '0) ? queue[rd_ptr] : last_instr;
    assign bus.if_pc    = deliver_pc;

    assign issue = bus.imem_req && bus.imem_gnt;
    assign pop   = bus.if_valid && bus.if_ready;
    assign push  = bus.imem_rvalid && !redirect && (discard == '0);

    always_comb begin
        state_next    = state;
        inflight_next = inflight + CNT_W'(issue) - CNT_W'(bus.imem_rvalid);
        count_next    = count;
        discard_next  = discard;
        if (redirect) begin
            count_next   = '0;
            discard_next = inflight - CNT_W'(bus.imem_rvalid);
        end else begin
            count_next = count + CNT_W'(push) - CNT_W'(pop);
            if (bus.imem_rvalid && (discard != '0)) begin
                discard_next = discard - CNT_W'(1);
            end
        end
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (redirect && (inflight_next != '0)) state_next = DRAIN;
            DRAIN:   if (discard_next == '0) state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            inflight   <= '0;
            count      <= '0;
            discard    <= '0;
            fetch_pc   <= RESET_PC;
            deliver_pc <= RESET_PC;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            last_instr <= '0;
        end else begin
            state    <= state_next;
            inflight <= inflight_next;
            count    <= count_next;
            discard  <= discard_next;
            if (redirect) begin
                fetch_pc   <= target_pc;
                deliver_pc <= target_pc;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (issue) fetch_pc <= fetch_pc + PC_STEP;
                if (push)  wr_ptr <= ptr_inc(wr_ptr);
                if (pop) begin
                    deliver_pc <= deliver_pc + PC_STEP;
                    rd_ptr     <= ptr_inc(rd_ptr);
                    last_instr <= queue[rd_ptr];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) queue[i] <= '0;
        end else if (push) begin
            queue[wr_ptr] <= bus.imem_rdata;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (pop)      perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

    assert property (@(posedge clk) disable iff (!rst_n) !(bus.imem_rvalid && (inflight == '0)));
    assert property (@(posedge clk) disable iff (!rst_n) count <= CNT_W'(DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n) discard <= inflight);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: table-driven reset/stream/stall vectors, hand-written redirect/wrap/reset
// sequences and a randomized run, all compared against a delivered-stream reference model.
module tb_ifetch_ctrl;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    ifetch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] data;
        int          due;
        bit          stale;
    } rd_t;

    typedef struct {
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    rd_t         pending[$];
    vec_t        vectors[$];
    vec_t        cur_row;
    bit          use_row;
    int          cyc, lat_min, lat_max;
    int          checks, errors;

    logic [31:0] m_fetch_pc, m_deliver_pc, m_last_instr;
    bit          m_boot;
    int          m_queued, m_pops, m_redirects, rand_pops;

    bit          dut_popped;
    logic [31:0] dut_pop_pc, dut_pop_instr;

    // Memory image: word i holds i+1.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) + 32'd1;
    endfunction

    function automatic vec_t mk(input logic rdy, input logic req, input logic [31:0] addr,
                                input logic v, input logic [31:0] pc, input logic [31:0] instr);
        vec_t r;
        r.rdy = rdy; r.exp_req = req; r.exp_addr = addr;
        r.exp_valid = v; r.exp_pc = pc; r.exp_instr = instr;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic modelReset();
        pending.delete();
        m_fetch_pc   = 32'h0;
        m_deliver_pc = 32'h0;
        m_last_instr = 32'h0;
        m_boot       = 1'b1;
        m_queued     = 0;
        m_pops       = 0;
        m_redirects  = 0;
    endtask

    task automatic checkOutput(input logic exp_req, input logic exp_valid);
        check("imem_req", 32'(bus.imem_req), 32'(exp_req));
        check("imem_addr", bus.imem_addr, m_fetch_pc);
        check("if_valid", 32'(bus.if_valid), 32'(exp_valid));
        check("if_pc", bus.if_pc, m_deliver_pc);
        if (!bus.redirect_valid)
            check("if_instr", bus.if_instr, (m_queued != 0) ? mem_word(m_deliver_pc) : m_last_instr);
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, 32'(m_pops));
        check("perf_flush_cnt", perf_flush_cnt, 32'(m_redirects));
`endif
        if (use_row) begin
            check("vec imem_req", 32'(bus.imem_req), 32'(cur_row.exp_req));
            check("vec imem_addr", bus.imem_addr, cur_row.exp_addr);
            check("vec if_valid", 32'(bus.if_valid), 32'(cur_row.exp_valid));
            check("vec if_pc", bus.if_pc, cur_row.exp_pc);
            check("vec if_instr", bus.if_instr, cur_row.exp_instr);
        end
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance model at the rising edge.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy, input logic gnt);
        logic        rv, exp_req, exp_valid, pop, issued;
        logic [31:0] addr;
        int          lat;
        rv = (pending.size() != 0) && (pending[0].due <= cyc);
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.if_ready       = rdy;
        bus.imem_gnt       = gnt;
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rv ? pending[0].data : 32'hDEAD_BEEF;
        exp_req   = !m_boot && !redir && ((pending.size() + m_queued) < DEPTH);
        exp_valid = (m_queued != 0) && !redir;
        pop       = exp_valid && rdy;
        @(negedge clk);
        checkOutput(exp_req, exp_valid);
        if (bus.if_valid && rdy && !dut_popped) begin
            dut_popped    = 1'b1;
            dut_pop_pc    = bus.if_pc;
            dut_pop_instr = bus.if_instr;
        end
        issued = bus.imem_req && gnt;
        addr   = bus.imem_addr;
        @(posedge clk);
        if (redir) begin
            if (rv) void'(pending.pop_front());
            foreach (pending[i]) pending[i].stale = 1'b1;
            m_queued     = 0;
            m_fetch_pc   = rpc & ~32'h3;
            m_deliver_pc = rpc & ~32'h3;
            m_redirects++;
        end else begin
            if (pop) begin
                m_last_instr = mem_word(m_deliver_pc);
                m_deliver_pc = m_deliver_pc + 32'd4;
                m_queued--;
                m_pops++;
                rand_pops++;
            end
            if (rv) begin
                if (!pending[0].stale) m_queued++;
                void'(pending.pop_front());
            end
            if (exp_req && gnt) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (issued) begin
            lat = (lat_max > lat_min) ? int'($urandom_range(lat_max, lat_min)) : lat_min;
            pending.push_back('{data: mem_word(addr), due: cyc + lat, stale: 1'b0});
        end
        m_boot = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic doReset(input string tag);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        rst_n = 1'b0;
        #1;
        check({tag, " reset imem_req"}, 32'(bus.imem_req), 32'h0);
        check({tag, " reset imem_addr"}, bus.imem_addr, 32'h0);
        check({tag, " reset if_valid"}, 32'(bus.if_valid), 32'h0);
        check({tag, " reset if_pc"}, bus.if_pc, 32'h0);
        check({tag, " reset if_instr"}, bus.if_instr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        check({tag, " reset perf_fetch_cnt"}, perf_fetch_cnt, 32'h0);
        check({tag, " reset perf_flush_cnt"}, perf_flush_cnt, 32'h0);
`endif
        modelReset();
        repeat (2) @(posedge clk);
        cyc += 2;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached after %0d cycles", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; use_row = 1'b0; rand_pops = 0;
        lat_min = 1; lat_max = 1;
        dut_popped = 1'b0; dut_pop_pc = '0; dut_pop_instr = '0;

        // rdy, req, addr, valid, pc, instr -- 1-cycle imem, gnt=1, stall in rows 9..13
        vectors.push_back(mk(1, 0, 32'h00, 0, 32'h00, 0));
        vectors.push_back(mk(1, 1, 32'h00, 0, 32'h00, 0));
        vectors.push_back(mk(1, 1, 32'h04, 0, 32'h00, 0));
        vectors.push_back(mk(1, 0, 32'h08, 1, 32'h00, 1));
        vectors.push_back(mk(1, 1, 32'h08, 1, 32'h04, 2));
        vectors.push_back(mk(1, 1, 32'h0C, 0, 32'h08, 2));
        vectors.push_back(mk(1, 0, 32'h10, 1, 32'h08, 3));
        vectors.push_back(mk(1, 1, 32'h10, 1, 32'h0C, 4));
        vectors.push_back(mk(1, 1, 32'h14, 0, 32'h10, 4));
        for (int i = 0; i < 5; i++) vectors.push_back(mk(0, 0, 32'h18, 1, 32'h10, 5));
        vectors.push_back(mk(1, 0, 32'h18, 1, 32'h10, 5));
        vectors.push_back(mk(1, 1, 32'h18, 1, 32'h14, 6));
        vectors.push_back(mk(1, 1, 32'h1C, 0, 32'h18, 6));

        $display("[TB] T1-T3: reset, streaming and stall vectors");
        doReset("T1");
        use_row = 1'b1;
        foreach (vectors[i]) begin
            cur_row = vectors[i];
            applyStimulus(1'b0, 32'h0, vectors[i].rdy, 1'b1);
        end
        use_row = 1'b0;

        $display("[TB] T4: redirect with two reads in flight");
        doReset("T4");
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 40 && pending.size() != 2; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        check("T4 inflight reached 2", 32'(pending.size()), 32'd2);
        applyStimulus(1'b1, 32'h103, 1'b1, 1'b1);
        dut_popped = 1'b0;
        for (int i = 0; i < 40 && !dut_popped; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        check("T4 delivery seen", 32'(dut_popped), 32'd1);
        check("T4 first if_pc", dut_pop_pc, 32'h100);
        check("T4 first if_instr", dut_pop_instr, 32'h41);

        $display("[TB] T5: redirect together with rvalid and pop");
        doReset("T5");
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 50; i++) begin
            if (pending.size() != 0 && pending[0].due <= cyc && m_queued != 0) break;
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        end
        check("T5 rvalid+queued found", 32'(pending.size() != 0 && pending[0].due <= cyc && m_queued != 0), 32'd1);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        check("T5 no pop at redirect", bus.if_pc, 32'h200);
        dut_popped = 1'b0;
        for (int i = 0; i < 40 && !dut_popped; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        check("T5 delivery seen", 32'(dut_popped), 32'd1);
        check("T5 first if_pc", dut_pop_pc, 32'h200);
        check("T5 first if_instr", dut_pop_instr, 32'h81);

        $display("[TB] T6: address wrap and mid-run reset");
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        dut_popped = 1'b0;
        for (int i = 0; i < 40 && !dut_popped; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        check("T6 pc before wrap", dut_pop_pc, 32'hFFFF_FFFC);
        check("T6 instr before wrap", dut_pop_instr, 32'h4000_0000);
        dut_popped = 1'b0;
        for (int i = 0; i < 40 && !dut_popped; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        check("T6 pc after wrap", dut_pop_pc, 32'h0);
        check("T6 instr after wrap", dut_pop_instr, 32'h1);
        for (int i = 0; i < 20 && pending.size() != 1; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        check("T6 inflight reached 1", 32'(pending.size()), 32'd1);
        doReset("T6");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

        $display("[TB] randomized run");
        lat_min = 1; lat_max = 4;
        rand_pops = 0;
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(15, 0) == 0), $urandom,
                          ($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0));
        end
        check("random run delivers >=20", 32'(rand_pops >= 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
